decode_stage_p: RTL and testbench
=================================

Name: decode_stage_p

Overview:
- Parametrised ID stage for the pipelined MIPS core.
- Contains the GPR file with write-back bypass, an N-source forwarding mux, Tuse/Tnew stall detection, early branch/jr resolution and the ID/EX pipeline register.
- Sits between the IF/ID register and the E stage. Instruction field decode (op/func to control) stays upstream; this block takes pre-decoded fields.

Parameters:
- DATA_W, 32: datapath width.
- ADDR_W, 5: register address width; the file holds 2**ADDR_W registers.
- FWD_N, 2: number of forwarding sources. Index 0 is the youngest (E/M) and has highest priority.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid_i  in  1  D-stage holds a real instruction.
- pc_d_i  in  DATA_W  PC of the D instruction.
- rs_i, rt_i  in  ADDR_W  source register addresses.
- use_rs_i, use_rt_i  in  1  operand is actually read.
- tuse_rs_i, tuse_rt_i  in  2  cycles until the operand is needed (0 = in D).
- br_op_i  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 jr.
- br_off_i  in  DATA_W  sign-extended offset, already shifted left by 2.
- wb_we_i  in  1  write-back enable.
- wb_addr_i  in  ADDR_W  write-back register address.
- wb_data_i  in  DATA_W  write-back data.
- fwd_valid_i  in  FWD_N  source i writes a register.
- fwd_addr_i  in  FWD_N*ADDR_W  destination of source i.
- fwd_tnew_i  in  FWD_N*2  cycles until source i data is ready.
- fwd_data_i  in  FWD_N*DATA_W  source i data (valid only when its tnew==0).
- flush_i  in  1  kill the D instruction.
- stall_o  out  1  hold PC and IF/ID.
- redirect_o  out  1  taken branch/jr.
- redirect_pc_o  out  DATA_W  target address.
- ex_valid_o  out  1  ID/EX register: instruction valid.
- ex_pc_o  out  DATA_W  ID/EX register: PC.
- ex_rs_o, ex_rt_o  out  ADDR_W  ID/EX register: source addresses.
- ex_rs_val_o, ex_rt_val_o  out  DATA_W  ID/EX register: operand values.
- stall_cnt_o  out  32  saturating count of stall cycles.

Behaviour:
- Reset (reset low, asynchronous): all GPRs = 0; all ex_* outputs = 0; stall_cnt_o = 0. Combinational outputs follow their inputs.
- GPR write: on posedge when wb_we_i=1 and wb_addr_i!=0. Register 0 always reads 0.
- Operand select, per operand, in this order:
  - Address 0 gives 0.
  - Otherwise take the lowest index i with fwd_valid_i[i]=1 and fwd_addr==addr.
    - If its tnew==0, use fwd_data[i].
    - If its tnew!=0, use the stale GPR value; E re-forwards using ex_rs_o/ex_rt_o.
  - If no source matches, use wb_data_i when wb_we_i=1 and wb_addr_i==addr (write-before-read); otherwise the GPR value.
- Hazard: the operand hits when it is used and the matching highest-priority source has tnew > tuse.
  - stall_o = instr_valid_i & (rs hit | rt hit).
  - A lower-priority match never causes a stall when a higher-priority source matches.
- Branch resolution happens only when instr_valid_i=1, stall_o=0 and flush_i=0:
  - beq taken when rs==rt; bne when rs!=rt; blez when signed rs<=0; bgtz when signed rs>0; jr always.
  - redirect_pc_o = pc_d_i + 4 + br_off_i for branches; rs value for jr. Addition wraps modulo 2**DATA_W.
  - redirect_o = 0 otherwise; redirect_pc_o is don't-care when redirect_o=0.
- ID/EX register update, priority order:
  - flush_i=1: bubble (ex_valid_o=0, all ex_* fields 0).
  - stall_o=1: bubble inserted; the D instruction is held upstream.
  - Otherwise capture: ex_valid_o = instr_valid_i, plus pc, addresses and selected values.
  - Latency from D inputs to ex_* outputs is 1 cycle.
- stall_cnt_o: +1 on each posedge with stall_o=1; saturates at 32'hFFFFFFFF; cleared only by reset.
- Reset mid-stall: bubble state and counter clear immediately; no held instruction remains inside the block.

Test Plan:
- Write $5=0x1234 via WB, then read rs=5 in the next cycle -> ex_rs_val_o=0x1234. Write $0=0xFFFF -> reads of $0 return 0.
- Same cycle: wb writes $7=0xAA and D reads rt=7 -> ex_rt_val_o=0xAA (bypass).
- fwd0 {addr 8, tnew 0, data 0x11} and fwd1 {addr 8, tnew 0, data 0x22}; rs=8 -> 0x11 selected.
- lw-use case: fwd0 {addr 9, tnew 1}, beq with rs=9, tuse 0 -> stall_o=1 for 1 cycle, ex_valid_o=0 that cycle, stall_cnt_o=1. Next cycle tnew 0, data 3, rt val 3 -> redirect_o=1, redirect_pc_o=pc+4+off.
- bgtz with rs=0x80000000 -> not taken. jr with rs=0x00400010 -> redirect_pc_o=0x00400010.
- flush_i and a stall in the same cycle -> bubble. Assert reset low mid-stream -> ex_* and stall_cnt_o read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage_p_if.sv
// Signal bundle for decode_stage_p. It carries the pre-decoded D-stage operands, the
// write-back port, the forwarding network, the hazard/redirect outputs and the ID/EX fields.
interface decode_stage_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FWD_N  = 2
);
  logic                    instr_valid_i;
  logic [DATA_W-1:0]       pc_d_i;
  logic [ADDR_W-1:0]       rs_i;
  logic [ADDR_W-1:0]       rt_i;
  logic                    use_rs_i;
  logic                    use_rt_i;
  logic [1:0]              tuse_rs_i;
  logic [1:0]              tuse_rt_i;
  logic [2:0]              br_op_i;
  logic [DATA_W-1:0]       br_off_i;
  logic                    wb_we_i;
  logic [ADDR_W-1:0]       wb_addr_i;
  logic [DATA_W-1:0]       wb_data_i;
  logic [FWD_N-1:0]        fwd_valid_i;
  logic [FWD_N*ADDR_W-1:0] fwd_addr_i;
  logic [FWD_N*2-1:0]      fwd_tnew_i;
  logic [FWD_N*DATA_W-1:0] fwd_data_i;
  logic                    flush_i;
  logic                    stall_o;
  logic                    redirect_o;
  logic [DATA_W-1:0]       redirect_pc_o;
  logic                    ex_valid_o;
  logic [DATA_W-1:0]       ex_pc_o;
  logic [ADDR_W-1:0]       ex_rs_o;
  logic [ADDR_W-1:0]       ex_rt_o;
  logic [DATA_W-1:0]       ex_rs_val_o;
  logic [DATA_W-1:0]       ex_rt_val_o;
  logic [31:0]             stall_cnt_o;

  modport master (
    output instr_valid_i, pc_d_i, rs_i, rt_i, use_rs_i, use_rt_i, tuse_rs_i, tuse_rt_i,
           br_op_i, br_off_i, wb_we_i, wb_addr_i, wb_data_i, fwd_valid_i, fwd_addr_i,
           fwd_tnew_i, fwd_data_i, flush_i,
    input  stall_o, redirect_o, redirect_pc_o, ex_valid_o, ex_pc_o, ex_rs_o, ex_rt_o,
           ex_rs_val_o, ex_rt_val_o, stall_cnt_o
  );

  modport slave (
    input  instr_valid_i, pc_d_i, rs_i, rt_i, use_rs_i, use_rt_i, tuse_rs_i, tuse_rt_i,
           br_op_i, br_off_i, wb_we_i, wb_addr_i, wb_data_i, fwd_valid_i, fwd_addr_i,
           fwd_tnew_i, fwd_data_i, flush_i,
    output stall_o, redirect_o, redirect_pc_o, ex_valid_o, ex_pc_o, ex_rs_o, ex_rt_o,
           ex_rs_val_o, ex_rt_val_o, stall_cnt_o
  );
endinterface

// File: rtl/decode_stage_p.sv
// ID stage of the pipelined MIPS core. It holds the GPR file, the operand forwarding mux,
// Tuse/Tnew stall detection, early branch/jr resolution and the ID/EX register.
module decode_stage_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FWD_N  = 2
) (
  input logic             clk,
  input logic             reset,
  decode_stage_p_if.slave bus
);
  localparam int                NREG      = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] ZERO_D    = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] PC_STEP   = DATA_W'(3'd4);
  localparam logic [2:0]        BR_BEQ    = 3'd1;
  localparam logic [2:0]        BR_BNE    = 3'd2;
  localparam logic [2:0]        BR_BLEZ   = 3'd3;
  localparam logic [2:0]        BR_BGTZ   = 3'd4;
  localparam logic [2:0]        BR_JR     = 3'd5;

  logic [DATA_W-1:0] gprFile_r [NREG];
  logic [DATA_W-1:0] rsVal_s, rtVal_s, target_s;
  logic              rsHit_s, rtHit_s, stall_s, taken_s, resolve_s;
  logic              exValid_r;
  logic [DATA_W-1:0] exPc_r, exRsVal_r, exRtVal_r;
  logic [ADDR_W-1:0] exRs_r, exRt_r;
  logic [31:0]       stallCnt_r;

  // The youngest matching source shadows all older ones, even when it is not ready yet;
  // E re-forwards from its own bypass when tnew is nonzero, so the stale GPR value is fine here.
  function automatic void selOperand(
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    used,
    input  logic [1:0]              tuse,
    input  logic [DATA_W-1:0]       gprVal,
    input  logic [FWD_N-1:0]        fValid,
    input  logic [FWD_N*ADDR_W-1:0] fAddr,
    input  logic [FWD_N*2-1:0]      fTnew,
    input  logic [FWD_N*DATA_W-1:0] fData,
    input  logic                    wbWe,
    input  logic [ADDR_W-1:0]       wbAddr,
    input  logic [DATA_W-1:0]       wbData,
    output logic [DATA_W-1:0]       val,
    output logic                    hit
  );
    logic found;
    found = 1'b0;
    val   = gprVal;
    hit   = 1'b0;
    for (int i = 0; i < FWD_N; i++) begin
      if (!found && fValid[i] && (fAddr[i*ADDR_W +: ADDR_W] == addr)) begin
        found = 1'b1;
        hit   = used && (fTnew[i*2 +: 2] > tuse);
        if (fTnew[i*2 +: 2] == 2'd0) begin
          val = fData[i*DATA_W +: DATA_W];
        end else begin
          val = gprVal;
        end
      end else begin
        found = found;
      end
    end
    if (addr == ZERO_A) begin
      val = ZERO_D;
      hit = 1'b0;
    end else if (!found && wbWe && (wbAddr == addr)) begin
      val = wbData;
    end else begin
      val = val;
    end
  endfunction

  // Operand selection for rs/rt and the resulting load-use stall.
  always_comb begin
    rsVal_s = ZERO_D;
    rtVal_s = ZERO_D;
    rsHit_s = 1'b0;
    rtHit_s = 1'b0;
    selOperand(bus.rs_i, bus.use_rs_i, bus.tuse_rs_i, gprFile_r[bus.rs_i], bus.fwd_valid_i,
               bus.fwd_addr_i, bus.fwd_tnew_i, bus.fwd_data_i, bus.wb_we_i, bus.wb_addr_i,
               bus.wb_data_i, rsVal_s, rsHit_s);
    selOperand(bus.rt_i, bus.use_rt_i, bus.tuse_rt_i, gprFile_r[bus.rt_i], bus.fwd_valid_i,
               bus.fwd_addr_i, bus.fwd_tnew_i, bus.fwd_data_i, bus.wb_we_i, bus.wb_addr_i,
               bus.wb_data_i, rtVal_s, rtHit_s);
    stall_s = bus.instr_valid_i & (rsHit_s | rtHit_s);
  end

  // Early branch/jr condition and target evaluation.
  always_comb begin
    taken_s  = 1'b0;
    target_s = bus.pc_d_i + PC_STEP + bus.br_off_i;
    case (bus.br_op_i)
      BR_BEQ:  taken_s = (rsVal_s == rtVal_s);
      BR_BNE:  taken_s = (rsVal_s != rtVal_s);
      BR_BLEZ: taken_s = ($signed(rsVal_s) <= $signed(ZERO_D));
      BR_BGTZ: taken_s = ($signed(rsVal_s) > $signed(ZERO_D));
      BR_JR: begin
        taken_s  = 1'b1;
        target_s = rsVal_s;
      end
      default: taken_s = 1'b0;
    endcase
    resolve_s = bus.instr_valid_i & ~stall_s & ~bus.flush_i;
  end

  // GPR file; register 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        gprFile_r[i] <= ZERO_D;
      end
    end else if (bus.wb_we_i && (bus.wb_addr_i != ZERO_A)) begin
      gprFile_r[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  // ID/EX register: flush and stall both inject a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exValid_r <= 1'b0;
      exPc_r    <= ZERO_D;
      exRs_r    <= ZERO_A;
      exRt_r    <= ZERO_A;
      exRsVal_r <= ZERO_D;
      exRtVal_r <= ZERO_D;
    end else if (bus.flush_i || stall_s) begin
      exValid_r <= 1'b0;
      exPc_r    <= ZERO_D;
      exRs_r    <= ZERO_A;
      exRt_r    <= ZERO_A;
      exRsVal_r <= ZERO_D;
      exRtVal_r <= ZERO_D;
    end else begin
      exValid_r <= bus.instr_valid_i;
      exPc_r    <= bus.pc_d_i;
      exRs_r    <= bus.rs_i;
      exRt_r    <= bus.rt_i;
      exRsVal_r <= rsVal_s;
      exRtVal_r <= rtVal_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_r <= 32'd0;
    end else if (stall_s && (stallCnt_r != 32'hFFFF_FFFF)) begin
      stallCnt_r <= stallCnt_r + 32'd1;
    end
  end

  assign bus.stall_o       = stall_s;
  assign bus.redirect_o    = resolve_s & taken_s;
  assign bus.redirect_pc_o = target_s;
  assign bus.ex_valid_o    = exValid_r;
  assign bus.ex_pc_o       = exPc_r;
  assign bus.ex_rs_o       = exRs_r;
  assign bus.ex_rt_o       = exRt_r;
  assign bus.ex_rs_val_o   = exRsVal_r;
  assign bus.ex_rt_val_o   = exRtVal_r;
  assign bus.stall_cnt_o   = stallCnt_r;
endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: directed scenarios plus randomized traffic
// against a behavioural model of the register file, forwarding priority and hazards.
`timescale 1ns/1ps
module tb_decode_stage_p;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FN = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  decode_stage_p_if #(.DATA_W(DW), .ADDR_W(AW), .FWD_N(FN)) bus();
  decode_stage_p #(.DATA_W(DW), .ADDR_W(AW), .FWD_N(FN)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic          vld, useRs, useRt, wbWe, flush;
  logic [31:0]   pc, brOff, wbData;
  logic [4:0]    rs, rt, wbAddr;
  logic [1:0]    tuseRs, tuseRt;
  logic [2:0]    brOp;
  logic          fValid [FN];
  logic [4:0]    fAddr  [FN];
  logic [1:0]    fTnew  [FN];
  logic [31:0]   fData  [FN];

  logic [31:0]   gpr [32];
  logic [31:0]   expCnt;
  logic          expStall, expRedir, expExValid;
  logic [31:0]   expRedirPc, expExPc, expExRsVal, expExRtVal;
  logic [4:0]    expExRs, expExRt;
  logic          obsStall, obsRedir;
  logic [31:0]   obsRedirPc;

  task automatic clearStim();
    vld = 1'b0; pc = 32'd0; rs = 5'd0; rt = 5'd0; useRs = 1'b0; useRt = 1'b0;
    tuseRs = 2'd0; tuseRt = 2'd0; brOp = 3'd0; brOff = 32'd0;
    wbWe = 1'b0; wbAddr = 5'd0; wbData = 32'd0; flush = 1'b0;
    for (int i = 0; i < FN; i++) begin
      fValid[i] = 1'b0; fAddr[i] = 5'd0; fTnew[i] = 2'd0; fData[i] = 32'd0;
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
    expCnt = 32'd0;
  endtask

  task automatic drive();
    bus.instr_valid_i = vld; bus.pc_d_i = pc; bus.rs_i = rs; bus.rt_i = rt;
    bus.use_rs_i = useRs; bus.use_rt_i = useRt; bus.tuse_rs_i = tuseRs; bus.tuse_rt_i = tuseRt;
    bus.br_op_i = brOp; bus.br_off_i = brOff; bus.wb_we_i = wbWe; bus.wb_addr_i = wbAddr;
    bus.wb_data_i = wbData; bus.flush_i = flush;
    for (int i = 0; i < FN; i++) begin
      bus.fwd_valid_i[i]         = fValid[i];
      bus.fwd_addr_i[i*AW +: AW] = fAddr[i];
      bus.fwd_tnew_i[i*2 +: 2]   = fTnew[i];
      bus.fwd_data_i[i*DW +: DW] = fData[i];
    end
  endtask

  // Reference: register value as a program would see it, plus whether it is not yet available.
  function automatic void modelOp(input logic [4:0] a, input logic u, input logic [1:0] tu,
                                  output logic [31:0] v, output logic h);
    int m;
    m = -1;
    for (int i = FN - 1; i >= 0; i--) if (fValid[i] && fAddr[i] == a) m = i;
    v = gpr[a];
    h = 1'b0;
    if (a == 5'd0) v = 32'd0;
    else if (m >= 0) begin
      h = u && (fTnew[m] > tu);
      v = (fTnew[m] == 2'd0) ? fData[m] : gpr[a];
    end else if (wbWe && wbAddr == a) v = wbData;
  endfunction

  task automatic runCycle();
    logic [31:0] rsv, rtv;
    logic rsh, rth, taken;
    drive();
    #1;
    obsStall = bus.stall_o; obsRedir = bus.redirect_o; obsRedirPc = bus.redirect_pc_o;
    modelOp(rs, useRs, tuseRs, rsv, rsh);
    modelOp(rt, useRt, tuseRt, rtv, rth);
    expStall = vld && (rsh || rth);
    case (brOp)
      3'd1: taken = (rsv == rtv);
      3'd2: taken = (rsv != rtv);
      3'd3: taken = ($signed(rsv) <= 0);
      3'd4: taken = ($signed(rsv) > 0);
      3'd5: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    expRedir = vld && !expStall && !flush && taken;
    expRedirPc = (brOp == 3'd5) ? rsv : pc + 32'd4 + brOff;
    @(posedge clk);
    if (flush || expStall) begin
      expExValid = 1'b0; expExPc = 32'd0; expExRs = 5'd0; expExRt = 5'd0;
      expExRsVal = 32'd0; expExRtVal = 32'd0;
    end else begin
      expExValid = vld; expExPc = pc; expExRs = rs; expExRt = rt;
      expExRsVal = rsv; expExRtVal = rtv;
    end
    if (expStall && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 32'd1;
    if (wbWe && wbAddr != 5'd0) gpr[wbAddr] = wbData;
    #1;
  endtask

  task automatic test_reset();
    clearStim(); clearModel(); drive();
    #2;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %h exp 0", bus.ex_valid_o); end
    checks++; if (bus.ex_pc_o !== 32'd0) begin errors++; $display("FAIL reset_ex_pc got %h exp 0", bus.ex_pc_o); end
    checks++; if (bus.ex_rs_val_o !== 32'd0) begin errors++; $display("FAIL reset_ex_rs_val got %h exp 0", bus.ex_rs_val_o); end
    checks++; if (bus.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %h exp 0", bus.stall_cnt_o); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_gpr_write();
    clearStim(); wbWe = 1'b1; wbAddr = 5'd5; wbData = 32'h1234; runCycle();
    clearStim(); vld = 1'b1; pc = 32'h40; rs = 5'd5; useRs = 1'b1; runCycle();
    checks++; if (bus.ex_rs_val_o !== 32'h1234) begin errors++; $display("FAIL gpr_read5 got %h exp 1234", bus.ex_rs_val_o); end
    checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 32'h40) begin errors++; $display("FAIL gpr_capture got v=%h pc=%h exp v=1 pc=40", bus.ex_valid_o, bus.ex_pc_o); end
    clearStim(); wbWe = 1'b1; wbAddr = 5'd0; wbData = 32'hFFFF; runCycle();
    clearStim(); vld = 1'b1; rs = 5'd0; rt = 5'd0; useRs = 1'b1; useRt = 1'b1; runCycle();
    checks++; if (bus.ex_rs_val_o !== 32'd0 || bus.ex_rt_val_o !== 32'd0) begin errors++; $display("FAIL gpr_zero got %h/%h exp 0/0", bus.ex_rs_val_o, bus.ex_rt_val_o); end
  endtask

  task automatic test_wb_bypass();
    clearStim(); vld = 1'b1; rt = 5'd7; useRt = 1'b1; wbWe = 1'b1; wbAddr = 5'd7; wbData = 32'hAA; runCycle();
    checks++; if (bus.ex_rt_val_o !== 32'hAA) begin errors++; $display("FAIL wb_bypass got %h exp aa", bus.ex_rt_val_o); end
    checks++; if (bus.ex_rt_o !== 5'd7) begin errors++; $display("FAIL wb_bypass_addr got %h exp 7", bus.ex_rt_o); end
  endtask

  task automatic test_fwd_priority();
    clearStim(); vld = 1'b1; rs = 5'd8; useRs = 1'b1;
    fValid[0] = 1'b1; fAddr[0] = 5'd8; fData[0] = 32'h11;
    fValid[1] = 1'b1; fAddr[1] = 5'd8; fData[1] = 32'h22;
    runCycle();
    checks++; if (bus.ex_rs_val_o !== 32'h11) begin errors++; $display("FAIL fwd_priority got %h exp 11", bus.ex_rs_val_o); end
    fTnew[1] = 2'd3; runCycle();
    checks++; if (obsStall !== 1'b0) begin errors++; $display("FAIL fwd_low_prio_nostall got %h exp 0", obsStall); end
    checks++; if (bus.ex_rs_val_o !== 32'h11) begin errors++; $display("FAIL fwd_low_prio_val got %h exp 11", bus.ex_rs_val_o); end
  endtask

  task automatic test_load_use();
    clearStim(); wbWe = 1'b1; wbAddr = 5'd10; wbData = 32'd3; runCycle();
    clearStim(); vld = 1'b1; pc = 32'h100; brOp = 3'd1; brOff = 32'h20;
    rs = 5'd9; rt = 5'd10; useRs = 1'b1; useRt = 1'b1;
    fValid[0] = 1'b1; fAddr[0] = 5'd9; fTnew[0] = 2'd1;
    runCycle();
    checks++; if (obsStall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %h exp 1", obsStall); end
    checks++; if (obsRedir !== 1'b0) begin errors++; $display("FAIL loaduse_noredir got %h exp 0", obsRedir); end
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL loaduse_bubble got %h exp 0", bus.ex_valid_o); end
    checks++; if (bus.stall_cnt_o !== 32'd1) begin errors++; $display("FAIL loaduse_cnt got %h exp 1", bus.stall_cnt_o); end
    fTnew[0] = 2'd0; fData[0] = 32'd3; runCycle();
    checks++; if (obsStall !== 1'b0) begin errors++; $display("FAIL loaduse_release got %h exp 0", obsStall); end
    checks++; if (obsRedir !== 1'b1 || obsRedirPc !== 32'h124) begin errors++; $display("FAIL loaduse_beq got r=%h pc=%h exp r=1 pc=124", obsRedir, obsRedirPc); end
    checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rs_val_o !== 32'd3) begin errors++; $display("FAIL loaduse_capture got v=%h rs=%h exp v=1 rs=3", bus.ex_valid_o, bus.ex_rs_val_o); end
  endtask

  task automatic test_branch_edges();
    clearStim(); vld = 1'b1; pc = 32'h1000; brOff = 32'hFFFF_FFF0; rs = 5'd11; rt = 5'd11;
    useRs = 1'b1; fValid[0] = 1'b1; fAddr[0] = 5'd11; fData[0] = 32'h8000_0000;
    brOp = 3'd4; runCycle();
    checks++; if (obsRedir !== 1'b0) begin errors++; $display("FAIL bgtz_neg got %h exp 0", obsRedir); end
    brOp = 3'd3; runCycle();
    checks++; if (obsRedir !== 1'b1 || obsRedirPc !== 32'h0FF4) begin errors++; $display("FAIL blez_neg got r=%h pc=%h exp r=1 pc=ff4", obsRedir, obsRedirPc); end
    brOp = 3'd2; useRt = 1'b1; runCycle();
    checks++; if (obsRedir !== 1'b0) begin errors++; $display("FAIL bne_equal got %h exp 0", obsRedir); end
    brOp = 3'd5; useRt = 1'b0; fData[0] = 32'h0040_0010; runCycle();
    checks++; if (obsRedir !== 1'b1 || obsRedirPc !== 32'h0040_0010) begin errors++; $display("FAIL jr_target got r=%h pc=%h exp r=1 pc=400010", obsRedir, obsRedirPc); end
    pc = 32'hFFFF_FFFC; brOff = 32'h8; brOp = 3'd1; runCycle();
    checks++; if (obsRedir !== 1'b1 || obsRedirPc !== 32'h8) begin errors++; $display("FAIL beq_wrap got r=%h pc=%h exp r=1 pc=8", obsRedir, obsRedirPc); end
  endtask

  task automatic test_flush_stall();
    clearStim(); vld = 1'b1; pc = 32'h300; rs = 5'd5; useRs = 1'b1; runCycle();
    flush = 1'b1; brOp = 3'd5; tuseRs = 2'd1;
    fValid[0] = 1'b1; fAddr[0] = 5'd5; fTnew[0] = 2'd3; runCycle();
    checks++; if (obsStall !== 1'b1 || obsRedir !== 1'b0) begin errors++; $display("FAIL flush_stall_comb got s=%h r=%h exp s=1 r=0", obsStall, obsRedir); end
    checks++; if (bus.ex_valid_o !== 1'b0 || bus.ex_pc_o !== 32'd0 || bus.ex_rs_o !== 5'd0) begin errors++; $display("FAIL flush_stall_bubble got v=%h pc=%h rs=%h exp 0", bus.ex_valid_o, bus.ex_pc_o, bus.ex_rs_o); end
    checks++; if (bus.stall_cnt_o !== expCnt) begin errors++; $display("FAIL flush_stall_cnt got %h exp %h", bus.stall_cnt_o, expCnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      vld = 1'($urandom_range(0, 3) != 0); pc = $urandom & 32'hFFFF_FFFC;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      useRs = 1'($urandom); useRt = 1'($urandom);
      tuseRs = 2'($urandom_range(0, 2)); tuseRt = 2'($urandom_range(0, 2));
      brOp = 3'($urandom); brOff = {{14{$urandom_range(0, 1) == 1}}, 16'($urandom), 2'b00};
      wbWe = 1'($urandom); wbAddr = 5'($urandom_range(0, 7)); wbData = $urandom;
      flush = 1'($urandom_range(0, 7) == 0);
      for (int i = 0; i < FN; i++) begin
        fValid[i] = 1'($urandom); fAddr[i] = 5'($urandom_range(1, 7));
        fTnew[i] = 2'($urandom); fData[i] = $urandom;
      end
      runCycle();
      checks++; if (obsStall !== expStall) begin errors++; $display("FAIL rnd_stall n=%0d got %h exp %h", n, obsStall, expStall); end
      checks++; if (obsRedir !== expRedir) begin errors++; $display("FAIL rnd_redirect n=%0d got %h exp %h", n, obsRedir, expRedir); end
      if (expRedir) begin
        checks++; if (obsRedirPc !== expRedirPc) begin errors++; $display("FAIL rnd_redirect_pc n=%0d got %h exp %h", n, obsRedirPc, expRedirPc); end
      end
      checks++; if (bus.ex_valid_o !== expExValid || bus.ex_pc_o !== expExPc) begin errors++; $display("FAIL rnd_ex_vpc n=%0d got %h/%h exp %h/%h", n, bus.ex_valid_o, bus.ex_pc_o, expExValid, expExPc); end
      checks++; if (bus.ex_rs_o !== expExRs || bus.ex_rt_o !== expExRt) begin errors++; $display("FAIL rnd_ex_addr n=%0d got %h/%h exp %h/%h", n, bus.ex_rs_o, bus.ex_rt_o, expExRs, expExRt); end
      checks++; if (bus.ex_rs_val_o !== expExRsVal) begin errors++; $display("FAIL rnd_ex_rs_val n=%0d got %h exp %h", n, bus.ex_rs_val_o, expExRsVal); end
      checks++; if (bus.ex_rt_val_o !== expExRtVal) begin errors++; $display("FAIL rnd_ex_rt_val n=%0d got %h exp %h", n, bus.ex_rt_val_o, expExRtVal); end
      checks++; if (bus.stall_cnt_o !== expCnt) begin errors++; $display("FAIL rnd_stall_cnt n=%0d got %h exp %h", n, bus.stall_cnt_o, expCnt); end
    end
  endtask

  task automatic test_reset_midstream();
    clearStim(); wbWe = 1'b1; wbAddr = 5'd5; wbData = 32'h5555; runCycle();
    clearStim(); vld = 1'b1; rs = 5'd5; useRs = 1'b1;
    fValid[0] = 1'b1; fAddr[0] = 5'd5; fTnew[0] = 2'd2; runCycle();
    fValid[0] = 1'b0; pc = 32'h500; runCycle();
    checks++; if (bus.ex_valid_o !== 1'b1 || bus.stall_cnt_o === 32'd0) begin errors++; $display("FAIL prereset_state got v=%h cnt=%h exp v=1 cnt>0", bus.ex_valid_o, bus.stall_cnt_o); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0 || bus.ex_pc_o !== 32'd0) begin errors++; $display("FAIL midreset_ex got v=%h pc=%h exp 0", bus.ex_valid_o, bus.ex_pc_o); end
    checks++; if (bus.ex_rs_val_o !== 32'd0 || bus.ex_rs_o !== 5'd0) begin errors++; $display("FAIL midreset_rs got %h/%h exp 0", bus.ex_rs_val_o, bus.ex_rs_o); end
    checks++; if (bus.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL midreset_cnt got %h exp 0", bus.stall_cnt_o); end
    clearModel();
    @(negedge clk); reset = 1'b1;
    clearStim(); vld = 1'b1; rs = 5'd5; useRs = 1'b1; runCycle();
    checks++; if (bus.ex_rs_val_o !== 32'd0 || bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL postreset_gpr got v=%h rs=%h exp v=1 rs=0", bus.ex_valid_o, bus.ex_rs_val_o); end
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_wb_bypass();
    test_fwd_priority();
    test_load_use();
    test_branch_edges();
    test_flush_stall();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
